// File: rtl/ram_slot_sched_pkg.sv
// Shared definitions for the packet-RAM slot scheduler: FSM encoding,
// readout framing constants and the FIFO-space requirement of one slot.
package ram_slot_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_RUN   = 2'd2,
    ST_GAP   = 2'd3
  } sched_state_e;

  // Each readout writes 3 timestamp words, the payload words and one extra
  // ethernet word into the downstream FIFO.
  localparam int TS_WORDS  = 3;
  localparam int ETH_EXTRA = 1;
  localparam int NEED_W    = 12;

  // Words the downstream FIFO must have free before a slot can be launched:
  // ceil(len/4) payload words plus the framing words.
  function automatic logic [NEED_W-1:0] need_words(input logic [15:0] len_bytes);
    logic [15:0] words;
    words = (len_bytes + 16'd3) >> 2;
    return NEED_W'(words) + NEED_W'(TS_WORDS + ETH_EXTRA);
  endfunction

endpackage

// File: rtl/ram_slot_sched_rr_pick.sv
// Round-robin first-set finder: searches req_i starting just after last_i,
// wrapping around, and returns the first requesting index.
module rr_pick #(
  parameter int NUM_SLOT = 8,
  parameter int PTR_W    = 3
) (
  input  logic [NUM_SLOT-1:0] req_i,
  input  logic [PTR_W-1:0]    last_i,
  output logic [PTR_W-1:0]    idx_o,
  output logic                found_o
);

  logic [PTR_W:0]     sum      [NUM_SLOT];
  logic [PTR_W-1:0]   cand_idx [NUM_SLOT];
  logic [NUM_SLOT-1:0] cand_hit;

  // Candidate gi is the slot gi+1 positions after last_i, modulo NUM_SLOT.
  generate
    for (genvar gi = 0; gi < NUM_SLOT; gi++) begin : g_cand
      assign sum[gi]      = {1'b0, last_i} + (PTR_W+1)'(gi + 1);
      assign cand_idx[gi] = (sum[gi] >= (PTR_W+1)'(NUM_SLOT))
                            ? PTR_W'(sum[gi] - (PTR_W+1)'(NUM_SLOT))
                            : PTR_W'(sum[gi]);
      assign cand_hit[gi] = req_i[cand_idx[gi]];
    end
  endgenerate

  // Scan from the farthest candidate down so the nearest hit wins.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = NUM_SLOT - 1; i >= 0; i--) begin
      if (cand_hit[i]) begin
        idx_o   = cand_idx[i];
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_slot_sched.sv
// Packet-RAM slot scheduler: tracks filled slots, launches them round-robin
// when the downstream FIFO has room, waits for reader completion (or times
// out), frees the slot and enforces a re-arm gap between launches.
module ram_slot_sched
  import ram_slot_sched_pkg::*;
#(
  parameter int NUM_SLOT   = 8,
  parameter int PTR_W      = 3,
  parameter int LEN_W      = 11,
  parameter int FIFO_DEPTH = 2048,
  parameter int CNT_W      = 12,
  parameter int GAP_CYC    = 4,
  parameter int TIMEOUT    = 4096
) (
  input  logic                user_clk,
  input  logic                user_reset,
  input  logic                enable,
  input  logic                slot_wr_done,
  input  logic [PTR_W-1:0]    slot_wr_ptr,
  input  logic [LEN_W-1:0]    slot_wr_len,
  input  logic [CNT_W-1:0]    fifo_wr_cnt,
  input  logic                flag_clr,
  output logic                ram_data_flag,
  output logic [PTR_W-1:0]    ram_ptr,
  output logic [LEN_W-1:0]    ram_dat_len,
  output logic [NUM_SLOT-1:0] slot_full,
  output logic                slot_ovf,
  output logic                timeout_err,
  output logic                busy,
  output logic [15:0]         served_cnt
);

  localparam int TMR_W = $clog2(TIMEOUT);
  localparam int GAP_W = $clog2(GAP_CYC + 1);

  sched_state_e        state_q, state_d;
  logic                flag_q, flag_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [LEN_W-1:0]    len_out_q, len_out_d;
  logic [NEED_W-1:0]   need_q, need_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [PTR_W-1:0]    last_q, last_d;
  logic [15:0]         served_q, served_d;
  logic                ovf_q, ovf_d;
  logic                tmo_q, tmo_d;
  logic                busy_q, busy_d;
  logic [NUM_SLOT-1:0] slot_full_q, slot_full_d;
  logic [LEN_W-1:0]    len_tab_q [NUM_SLOT];

  logic [NUM_SLOT-1:0] set_vec, clr_vec;
  logic [PTR_W-1:0]    pick_idx;
  logic                pick_found;
  logic                run_exit;
  logic                sel_busy;
  logic [CNT_W+1:0]    demand;
  logic                fits;

  rr_pick #(
    .NUM_SLOT (NUM_SLOT),
    .PTR_W    (PTR_W)
  ) u_rr_pick (
    .req_i   (slot_full_q),
    .last_i  (last_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  // Launch only if current fill plus the slot's whole readout fits.
  assign demand = (CNT_W+2)'(fifo_wr_cnt) + (CNT_W+2)'(need_q);
  assign fits   = (demand <= (CNT_W+2)'(FIFO_DEPTH));

  // The selected slot stays reserved from CHECK until its clear.
  assign sel_busy = (state_q == ST_CHECK) || (state_q == ST_RUN);

  generate
    for (genvar gi = 0; gi < NUM_SLOT; gi++) begin : g_slot
      localparam logic [PTR_W-1:0] SLOT_IDX = PTR_W'(gi);
      assign set_vec[gi] = slot_wr_done && (slot_wr_ptr == SLOT_IDX) &&
                           !slot_full_q[gi] && !(sel_busy && (ptr_q == SLOT_IDX));
      assign clr_vec[gi] = run_exit && (ptr_q == SLOT_IDX);
    end
  endgenerate

  // A write to one slot and the clear of another coexist in one cycle.
  assign slot_full_d = (slot_full_q & ~clr_vec) | set_vec;
  assign ovf_d       = slot_wr_done && !(|set_vec);

  // Next-state and datapath updates for the launch FSM.
  always_comb begin
    state_d   = state_q;
    flag_d    = flag_q;
    ptr_d     = ptr_q;
    len_out_d = len_out_q;
    need_d    = need_q;
    timer_d   = timer_q;
    gap_d     = gap_q;
    last_d    = last_q;
    served_d  = served_q;
    tmo_d     = 1'b0;
    run_exit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable && pick_found) begin
          ptr_d     = pick_idx;
          len_out_d = len_tab_q[pick_idx];
          need_d    = need_words(16'(len_tab_q[pick_idx]));
          state_d   = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (fits) begin
          flag_d  = 1'b1;
          timer_d = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (flag_clr) begin
          run_exit = 1'b1;
          served_d = served_q + 16'd1;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          run_exit = 1'b1;
          tmo_d    = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
        if (run_exit) begin
          flag_d  = 1'b0;
          last_d  = ptr_q;
          gap_d   = '0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_W'(GAP_CYC - 1)) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      state_q     <= ST_IDLE;
      flag_q      <= 1'b0;
      ptr_q       <= '0;
      len_out_q   <= '0;
      need_q      <= '0;
      timer_q     <= '0;
      gap_q       <= '0;
      last_q      <= PTR_W'(NUM_SLOT - 1);
      served_q    <= '0;
      ovf_q       <= 1'b0;
      tmo_q       <= 1'b0;
      busy_q      <= 1'b0;
      slot_full_q <= '0;
    end else begin
      state_q     <= state_d;
      flag_q      <= flag_d;
      ptr_q       <= ptr_d;
      len_out_q   <= len_out_d;
      need_q      <= need_d;
      timer_q     <= timer_d;
      gap_q       <= gap_d;
      last_q      <= last_d;
      served_q    <= served_d;
      ovf_q       <= ovf_d;
      tmo_q       <= tmo_d;
      busy_q      <= busy_d;
      slot_full_q <= slot_full_d;
    end
  end

  // Length table: captured only on an accepted slot write.
  always_ff @(posedge user_clk) begin
    for (int i = 0; i < NUM_SLOT; i++) begin
      if (user_reset) begin
        len_tab_q[i] <= '0;
      end else if (set_vec[i]) begin
        len_tab_q[i] <= slot_wr_len;
      end
    end
  end

  assign ram_data_flag = flag_q;
  assign ram_ptr       = ptr_q;
  assign ram_dat_len   = len_out_q;
  assign slot_full     = slot_full_q;
  assign slot_ovf      = ovf_q;
  assign timeout_err   = tmo_q;
  assign busy          = busy_q;
  assign served_cnt    = served_q;

endmodule

// File: tb/tb_ram_slot_sched.sv
// Scenario bench for ram_slot_sched: expected launches are queued when slots
// are written and checked when the scheduler raises ram_data_flag.
module tb_ram_slot_sched;

  localparam int NUM_SLOT   = 8;
  localparam int PTR_W      = 3;
  localparam int LEN_W      = 11;
  localparam int FIFO_DEPTH = 2048;
  localparam int CNT_W      = 12;
  localparam int GAP_CYC    = 4;
  localparam int TIMEOUT    = 4096;

  typedef struct packed {
    logic [PTR_W-1:0] ptr;
    logic [LEN_W-1:0] len;
  } exp_t;

  logic                user_clk = 1'b0;
  logic                user_reset = 1'b1;
  logic                enable = 1'b0;
  logic                slot_wr_done = 1'b0;
  logic [PTR_W-1:0]    slot_wr_ptr = '0;
  logic [LEN_W-1:0]    slot_wr_len = '0;
  logic [CNT_W-1:0]    fifo_wr_cnt = '0;
  logic                flag_clr = 1'b0;
  logic                ram_data_flag;
  logic [PTR_W-1:0]    ram_ptr;
  logic [LEN_W-1:0]    ram_dat_len;
  logic [NUM_SLOT-1:0] slot_full;
  logic                slot_ovf;
  logic                timeout_err;
  logic                busy;
  logic [15:0]         served_cnt;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  always #5 user_clk = ~user_clk;

  ram_slot_sched #(
    .NUM_SLOT   (NUM_SLOT),
    .PTR_W      (PTR_W),
    .LEN_W      (LEN_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W),
    .GAP_CYC    (GAP_CYC),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .user_clk      (user_clk),
    .user_reset    (user_reset),
    .enable        (enable),
    .slot_wr_done  (slot_wr_done),
    .slot_wr_ptr   (slot_wr_ptr),
    .slot_wr_len   (slot_wr_len),
    .fifo_wr_cnt   (fifo_wr_cnt),
    .flag_clr      (flag_clr),
    .ram_data_flag (ram_data_flag),
    .ram_ptr       (ram_ptr),
    .ram_dat_len   (ram_dat_len),
    .slot_full     (slot_full),
    .slot_ovf      (slot_ovf),
    .timeout_err   (timeout_err),
    .busy          (busy),
    .served_cnt    (served_cnt)
  );

  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  task automatic do_reset();
    user_reset   = 1'b1;
    enable       = 1'b0;
    slot_wr_done = 1'b0;
    flag_clr     = 1'b0;
    fifo_wr_cnt  = '0;
    repeat (2) tick();
    user_reset = 1'b0;
    sb.delete();
  endtask

  task automatic write_slot(input int p, input int len);
    slot_wr_done = 1'b1;
    slot_wr_ptr  = PTR_W'(p);
    slot_wr_len  = LEN_W'(len);
    tick();
    slot_wr_done = 1'b0;
    $display("write slot=%0d len=%0d ovf=%0b full=%b", p, len, slot_ovf, slot_full);
  endtask

  task automatic pulse_clr();
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
  endtask

  function automatic exp_t sb_pop();
    exp_t e;
    e = 'x;
    if (sb.size() != 0) e = sb.pop_front();
    return e;
  endfunction

  task automatic wait_flag_rise(input int limit, output int cyc);
    cyc = 0;
    while (ram_data_flag !== 1'b1 && cyc < limit) begin
      tick();
      cyc++;
    end
    if (ram_data_flag !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL launch_wait: no flag after %0d cycles, required a launch", cyc);
    end else begin
      $display("launch ptr=%0d len=%0d after %0d cycles", ram_ptr, ram_dat_len, cyc);
    end
  endtask

  task automatic wait_idle(input int limit);
    int cyc;
    cyc = 0;
    while (busy !== 1'b0 && cyc < limit) begin
      tick();
      cyc++;
    end
    if (busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL idle_wait: busy=%b after %0d cycles, required 0", busy, cyc);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({ram_data_flag, busy, slot_ovf, timeout_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: flag/busy/ovf/tmo=%b required 0000",
               {ram_data_flag, busy, slot_ovf, timeout_err});
    end
    checks++;
    if ({slot_full, served_cnt, ram_ptr, ram_dat_len} !== '0) begin
      errors++;
      $display("FAIL reset_data: full=%b served=%0d ptr=%0d len=%0d required all 0",
               slot_full, served_cnt, ram_ptr, ram_dat_len);
    end
    $display("reset done");
  endtask

  task automatic test_single();
    exp_t e;
    do_reset();
    enable = 1'b1;
    sb.push_back('{ptr: 3'd2, len: 11'd64});
    write_slot(2, 64);
    checks++;
    if (slot_full !== 8'b0000_0100) begin
      errors++;
      $display("FAIL single_full: slot_full=%b required 00000100", slot_full);
    end
    tick();
    checks++;
    if (ram_data_flag !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_check: flag=%b busy=%b required flag=0 busy=1", ram_data_flag, busy);
    end
    tick();
    checks++;
    if (ram_data_flag !== 1'b1) begin
      errors++;
      $display("FAIL single_latency: flag=%b at +3 cycles required 1", ram_data_flag);
    end
    e = sb_pop();
    checks++;
    if (ram_ptr !== e.ptr || ram_dat_len !== e.len) begin
      errors++;
      $display("FAIL single_slot: ptr=%0d len=%0d required ptr=%0d len=%0d", ram_ptr, ram_dat_len, e.ptr, e.len);
    end
    repeat (25) tick();
    checks++;
    if (ram_data_flag !== 1'b1 || ram_ptr !== 3'd2 || ram_dat_len !== 11'd64) begin
      errors++;
      $display("FAIL single_hold: flag=%b ptr=%0d len=%0d required 1/2/64", ram_data_flag, ram_ptr, ram_dat_len);
    end
    pulse_clr();
    checks++;
    if (ram_data_flag !== 1'b0 || slot_full !== 8'h00 || served_cnt !== 16'd1) begin
      errors++;
      $display("FAIL single_done: flag=%b full=%b served=%0d required 0/00000000/1",
               ram_data_flag, slot_full, served_cnt);
    end
    $display("single slot served=%0d", served_cnt);
    wait_idle(50);
  endtask

  task automatic test_round_robin();
    exp_t e;
    int   cyc;
    do_reset();
    enable = 1'b1;
    sb.push_back('{ptr: 3'd5, len: 11'd8});
    write_slot(5, 8);
    wait_flag_rise(50, cyc);
    e = sb_pop();
    checks++;
    if (ram_ptr !== e.ptr || ram_dat_len !== e.len) begin
      errors++;
      $display("FAIL rr_prime: ptr=%0d len=%0d required ptr=%0d len=%0d", ram_ptr, ram_dat_len, e.ptr, e.len);
    end
    enable = 1'b0;
    pulse_clr();
    wait_idle(50);
    write_slot(1, 12);
    write_slot(5, 20);
    write_slot(6, 28);
    sb.push_back('{ptr: 3'd6, len: 11'd28});
    sb.push_back('{ptr: 3'd1, len: 11'd12});
    sb.push_back('{ptr: 3'd5, len: 11'd20});
    checks++;
    if (slot_full !== 8'b0110_0010 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rr_blocked: full=%b busy=%b required 01100010 busy=0", slot_full, busy);
    end
    enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_flag_rise(50, cyc);
      if (k > 0) begin
        checks++;
        if (cyc < GAP_CYC + 2) begin
          errors++;
          $display("FAIL rr_gap: gap=%0d cycles required >= %0d", cyc, GAP_CYC + 2);
        end
      end
      e = sb_pop();
      checks++;
      if (ram_ptr !== e.ptr || ram_dat_len !== e.len) begin
        errors++;
        $display("FAIL rr_order: ptr=%0d len=%0d required ptr=%0d len=%0d", ram_ptr, ram_dat_len, e.ptr, e.len);
      end
      repeat (2) tick();
      pulse_clr();
    end
    checks++;
    if (served_cnt !== 16'd4 || slot_full !== 8'h00) begin
      errors++;
      $display("FAIL rr_served: served=%0d full=%b required 4/00000000", served_cnt, slot_full);
    end
    wait_idle(50);
  endtask

  task automatic test_backpressure();
    exp_t e;
    do_reset();
    enable      = 1'b1;
    fifo_wr_cnt = 12'd1700;
    sb.push_back('{ptr: 3'd0, len: 11'd1500});
    write_slot(0, 1500);
    repeat (10) tick();
    checks++;
    if (ram_data_flag !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_hold: flag=%b busy=%b required flag=0 busy=1", ram_data_flag, busy);
    end
    fifo_wr_cnt = 12'd1670;
    repeat (3) tick();
    checks++;
    if (ram_data_flag !== 1'b0) begin
      errors++;
      $display("FAIL bp_edge: flag=%b with one word short required 0", ram_data_flag);
    end
    fifo_wr_cnt = 12'd1669;
    tick();
    checks++;
    if (ram_data_flag !== 1'b1) begin
      errors++;
      $display("FAIL bp_launch: flag=%b one cycle after room required 1", ram_data_flag);
    end
    e = sb_pop();
    checks++;
    if (ram_ptr !== e.ptr || ram_dat_len !== e.len) begin
      errors++;
      $display("FAIL bp_slot: ptr=%0d len=%0d required ptr=%0d len=%0d", ram_ptr, ram_dat_len, e.ptr, e.len);
    end
    $display("backpressure launch ptr=%0d len=%0d", ram_ptr, ram_dat_len);
    pulse_clr();
    fifo_wr_cnt = '0;
    wait_idle(50);
  endtask

  task automatic test_timeout();
    exp_t e;
    int   cyc;
    do_reset();
    enable = 1'b1;
    sb.push_back('{ptr: 3'd7, len: 11'd100});
    write_slot(7, 100);
    wait_flag_rise(50, cyc);
    e = sb_pop();
    checks++;
    if (ram_ptr !== e.ptr || ram_dat_len !== e.len) begin
      errors++;
      $display("FAIL tmo_slot: ptr=%0d len=%0d required ptr=%0d len=%0d", ram_ptr, ram_dat_len, e.ptr, e.len);
    end
    enable = 1'b0;
    cyc = 0;
    while (timeout_err !== 1'b1 && cyc < TIMEOUT + 20) begin
      tick();
      cyc++;
    end
    checks++;
    if (cyc != TIMEOUT) begin
      errors++;
      $display("FAIL tmo_cycles: timeout_err after %0d cycles required %0d", cyc, TIMEOUT);
    end
    checks++;
    if (ram_data_flag !== 1'b0 || slot_full !== 8'h00 || served_cnt !== 16'd0) begin
      errors++;
      $display("FAIL tmo_exit: flag=%b full=%b served=%0d required 0/00000000/0",
               ram_data_flag, slot_full, served_cnt);
    end
    tick();
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_pulse: timeout_err=%b one cycle later required 0", timeout_err);
    end
    $display("timeout after %0d cycles", cyc);
    wait_idle(50);
  endtask

  task automatic test_overflow();
    exp_t e;
    int   cyc;
    do_reset();
    write_slot(3, 40);
    checks++;
    if (slot_ovf !== 1'b0 || slot_full !== 8'b0000_1000) begin
      errors++;
      $display("FAIL ovf_first: ovf=%b full=%b required 0/00001000", slot_ovf, slot_full);
    end
    write_slot(3, 99);
    checks++;
    if (slot_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_second: ovf=%b required 1", slot_ovf);
    end
    tick();
    checks++;
    if (slot_ovf !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ovf_pulse: ovf=%b busy=%b required 0/0", slot_ovf, busy);
    end
    sb.push_back('{ptr: 3'd3, len: 11'd40});
    enable = 1'b1;
    wait_flag_rise(50, cyc);
    e = sb_pop();
    checks++;
    if (ram_ptr !== e.ptr || ram_dat_len !== e.len) begin
      errors++;
      $display("FAIL ovf_keep_len: ptr=%0d len=%0d required ptr=%0d len=%0d", ram_ptr, ram_dat_len, e.ptr, e.len);
    end
    enable = 1'b0;
    tick();
    slot_wr_done = 1'b1;
    slot_wr_ptr  = 3'd4;
    slot_wr_len  = 11'd16;
    flag_clr     = 1'b1;
    tick();
    slot_wr_done = 1'b0;
    flag_clr     = 1'b0;
    checks++;
    if (slot_full !== 8'b0001_0000 || slot_ovf !== 1'b0 || served_cnt !== 16'd1) begin
      errors++;
      $display("FAIL ovf_same_cycle: full=%b ovf=%b served=%0d required 00010000/0/1",
               slot_full, slot_ovf, served_cnt);
    end
    $display("same-cycle write/clear full=%b", slot_full);
    wait_idle(50);
  endtask

  task automatic test_reset_mid_run();
    exp_t e;
    int   cyc;
    do_reset();
    enable = 1'b1;
    sb.push_back('{ptr: 3'd0, len: 11'd8});
    sb.push_back('{ptr: 3'd1, len: 11'd8});
    write_slot(0, 8);
    write_slot(1, 8);
    for (int k = 0; k < 2; k++) begin
      wait_flag_rise(50, cyc);
      e = sb_pop();
      checks++;
      if (ram_ptr !== e.ptr || ram_dat_len !== e.len) begin
        errors++;
        $display("FAIL rst_slot: ptr=%0d len=%0d required ptr=%0d len=%0d", ram_ptr, ram_dat_len, e.ptr, e.len);
      end
      if (k == 0) pulse_clr();
    end
    user_reset = 1'b1;
    tick();
    user_reset = 1'b0;
    checks++;
    if (ram_data_flag !== 1'b0 || slot_full !== 8'h00 || busy !== 1'b0 || served_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rst_mid_run: flag=%b full=%b busy=%b served=%0d required 0/00000000/0/0",
               ram_data_flag, slot_full, busy, served_cnt);
    end
    repeat (4) tick();
    checks++;
    if (busy !== 1'b0 || ram_data_flag !== 1'b0) begin
      errors++;
      $display("FAIL rst_stays_idle: busy=%b flag=%b required 0/0", busy, ram_data_flag);
    end
    $display("reset mid-run done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_overflow();
    test_reset_mid_run();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d launches outstanding required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_slot_sched.md
Name: ram_slot_sched

Overview:
- Scheduler for the shared packet-RAM slots read out by the per-group readers (one reader per group_id).
- Tracks which slots the receive side has filled and picks the next full slot round-robin.
- Launches a slot only when the downstream write FIFO has room for the whole readout. Drives the shared ram_data_flag/ram_ptr/ram_dat_len, waits for the reader's completion pulse, then frees the slot.
- Enforces the idle gap the readers need to re-arm between consecutive slots.

Parameters:
NUM_SLOT, 8, number of RAM slots (max 2**PTR_W)
PTR_W, 3, slot pointer width
LEN_W, 11, byte-length width
FIFO_DEPTH, 2048, downstream FIFO depth in 32-bit words
CNT_W, 12, FIFO fill-count width
GAP_CYC, 4, minimum cycles ram_data_flag stays low between launches (>=4)
TIMEOUT, 4096, max cycles in RUN before abort

Ports:
user_clk  in  1  clock
user_reset  in  1  synchronous active-high reset
enable  in  1  allow new launches
slot_wr_done  in  1  pulse: receive side finished writing a slot
slot_wr_ptr  in  PTR_W  slot index for slot_wr_done
slot_wr_len  in  LEN_W  byte length of that slot
fifo_wr_cnt  in  CNT_W  current downstream FIFO fill, in words
flag_clr  in  1  OR of all readers' completion pulses
ram_data_flag  out  1  slot-valid strobe to the readers
ram_ptr  out  PTR_W  slot being served
ram_dat_len  out  LEN_W  byte length of served slot
slot_full  out  NUM_SLOT  occupancy bitmap
slot_ovf  out  1  1-cycle pulse: write to an occupied slot
timeout_err  out  1  1-cycle pulse: RUN aborted on timeout
busy  out  1  FSM not in IDLE
served_cnt  out  16  completed slots, wraps at 65535->0

Behaviour:
- Reset: all outputs 0, FSM IDLE, rr pointer last = NUM_SLOT-1, timers 0, length table 0.
- Slot write:
  - slot_wr_done on a free slot sets slot_full[p] next cycle and stores len[p].
  - On an occupied slot, or the slot currently selected: slot_ovf pulses, no bit/length change.
- need = ceil(len/4) + 4 words (3 timestamp + ceil(len/4)+1 eth), 12-bit arithmetic; len=0 -> need=4.
- FSM:
  - IDLE: if enable and |slot_full, select the first set bit searching last+1 .. last (wrapping). Register it into ram_ptr/ram_dat_len and the need register. -> CHECK.
  - CHECK: if FIFO_DEPTH - fifo_wr_cnt >= need, assert ram_data_flag next cycle -> RUN; else stay. No timeout is applied in CHECK.
  - RUN:
    - ram_data_flag=1; ram_ptr/ram_dat_len held stable.
    - flag_clr: drop ram_data_flag, clear slot_full[ptr], increment served_cnt, last=ptr -> GAP.
    - timer reaching TIMEOUT-1 without flag_clr: same exit, but timeout_err pulses instead of served_cnt++. The slot is dropped.
  - GAP: ram_data_flag=0 for exactly GAP_CYC cycles -> IDLE. The earliest relaunch flag edge is GAP_CYC+2 cycles after the fall.
- flag_clr seen outside RUN is ignored.
- enable low: blocks IDLE->CHECK only; a slot already in CHECK/RUN completes.
- Same cycle: slot_wr_done on slot A and clear of slot B both apply. slot_wr_done on the slot being cleared is an overflow (slot still counted busy that cycle).
- user_reset mid-RUN: ram_data_flag drops the next cycle, and every slot is freed.
- All outputs registered.

Decomposition:
- Shared package: FSM state encoding (IDLE, CHECK, RUN, GAP), TS_WORDS=3, ETH_EXTRA=1, and the need-calculation function.
- One sub-module, rr_pick: a NUM_SLOT-wide round-robin first-set finder given the bitmap and last pointer. Returns the index and a found flag.

Test Plan:
- Single slot: write ptr=2 len=64, fifo_wr_cnt=0. Expect ram_ptr=2, ram_dat_len=64, flag high at +3 cycles. flag_clr after 25 cycles -> flag low, slot_full=0, served_cnt=1.
- Round-robin: slots 1,5,6 full, last=5. Expect service order 6,1,5. Gap between flag fall and next rise is >= GAP_CYC+2 cycles.
- Backpressure: len=1500 (need=379), fifo_wr_cnt=1700. FSM holds in CHECK, flag low. fifo_wr_cnt drops to 1669 -> launch next cycle.
- Timeout: launch and never assert flag_clr. At TIMEOUT cycles: timeout_err=1 for one cycle, slot freed, served_cnt unchanged.
- Overflow: write ptr=3 twice without service -> slot_ovf pulse on the second write, len[3] keeps the first value. Also the same-cycle write of slot 4 while slot 3 clears -> slot_full=8'b0001_0000.
- Reset mid-RUN: user_reset in RUN -> next cycle ram_data_flag=0, slot_full=0, busy=0, served_cnt=0.
